// File: rtl/servo_pkg.sv
// servo_pkg: shared parser states, reply bytes and unit-conversion helpers
// for the multi-channel servo controller.
package servo_pkg;

    typedef enum logic [2:0] {IDLE, NUM_C, NUM_A, NUM_P, NUM_S} state_t;

    localparam logic [7:0] RPL_K = 8'h4B;
    localparam logic [7:0] RPL_E = 8'h45;
    localparam logic [7:0] RPL_O = 8'h4F;

    function automatic int us_div(input int clk_freq);
        return clk_freq / 1_000_000;
    endfunction

    function automatic int step_div(input int clk_freq, input int step_ms);
        return clk_freq / 1000 * step_ms;
    endfunction

    // Roughly 7.25 us per degree; anything past 270 saturates at the upper limit.
    function automatic logic [15:0] angle_to_us(input logic [15:0] acc, input logic [15:0] min_us,
                                                input logic [15:0] max_us);
        return (acc > 16'd270) ? max_us : 16'(min_us + 16'(7 * acc) + (acc >> 2));
    endfunction

endpackage

// File: rtl/servo_pwm_bank.sv
// servo_pwm_bank: shared 1 us prescaler and frame counter driving NCH phase-aligned PWM outputs.
// Widths are latched at frame count 0, so a change never truncates or stretches a pulse mid-frame.
module servo_pwm_bank #(
    parameter int NCH      = 4,
    parameter int US_DIV   = 50,
    parameter int FRAME_US = 20000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    i_cur [NCH],
    output logic [NCH-1:0] o_pwm
);

    localparam int PW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

    logic [PW-1:0] r_pre;
    logic [15:0]   r_frame;
    logic [15:0]   r_shadow [NCH];
    logic [15:0]   w_shd [NCH];
    logic          w_us_tick;

    assign w_us_tick = (r_pre == PW'(US_DIV - 1));

    // During frame count 0 the live width is used directly so the first pulse is never short.
    for (genvar c = 0; c < NCH; c++) begin : g_shd
        assign w_shd[c] = (r_frame == '0) ? i_cur[c] : r_shadow[c];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre   <= '0;
            r_frame <= '0;
            o_pwm   <= '0;
            for (int i = 0; i < NCH; i++) r_shadow[i] <= '0;
        end else begin
            r_pre <= w_us_tick ? '0 : r_pre + PW'(1);
            if (w_us_tick) r_frame <= (r_frame == 16'(FRAME_US - 1)) ? '0 : r_frame + 16'd1;
            for (int i = 0; i < NCH; i++) begin
                r_shadow[i] <= w_shd[i];
                o_pwm[i]    <= (r_frame < w_shd[i]);
            end
        end
    end

endmodule

// File: rtl/bt_multi_servo_ctrl.sv
// bt_multi_servo_ctrl: parses channel-addressed ASCII servo commands from the UART byte stream,
// slews each channel toward its target and drives NCH phase-aligned 50 Hz PWM outputs.
module bt_multi_servo_ctrl import servo_pkg::*; #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int NCH      = 4,
    parameter int MIN_US   = 500,
    parameter int MAX_US   = 2500,
    parameter int FRAME_US = 20000,
    parameter int STEP_MS  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rx_valid,
    input  logic [7:0]     rx_data,
    input  logic           tx_busy,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    output logic [NCH-1:0] servo_pwm
);

    localparam int          US_DIV   = us_div(CLK_FREQ);
    localparam int          STEP_DIV = step_div(CLK_FREQ, STEP_MS);
    localparam int          SW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [15:0] MIN_W    = 16'(MIN_US);
    localparam logic [15:0] MAX_W    = 16'(MAX_US);
    localparam logic [15:0] MID_W    = 16'((MIN_US + MAX_US) / 2);
    localparam logic [15:0] X_W      = 16'(MIN_US + 978);

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_acc, w_acc_nxt, w_acc_dig, w_tgt_val;
    logic [2:0]    r_cnt, w_cnt_nxt;
    logic          r_ovf, w_ovf_nxt;
    logic [3:0]    r_sel;
    logic [15:0]   r_tgt [NCH];
    logic [15:0]   r_cur [NCH];
    logic [15:0]   r_slew [NCH];
    logic [15:0]   w_cur_nxt [NCH];
    logic          r_pend;
    logic [7:0]    r_pend_data, w_rpl;
    logic [SW-1:0] r_step;
    logic          w_tick, w_is_dig, w_is_term, w_in_num, w_is_cmd, w_err, w_launch;
    logic          w_rpl_vld, w_tgt_we, w_all_mid, w_sel_we, w_slew_we;

    assign w_is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign w_is_cmd  = (rx_data == "C") || (rx_data == "A") || (rx_data == "P") || (rx_data == "S");
    assign w_in_num  = (r_state != IDLE);
    assign w_acc_dig = r_acc * 16'd10 + 16'(rx_data[3:0]);
    assign w_tick    = (r_step == SW'(STEP_DIV - 1));
    assign w_launch  = r_pend && !tx_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_err       = 1'b0;
        w_rpl_vld   = 1'b0;
        w_rpl       = RPL_K;
        w_tgt_we    = 1'b0;
        w_tgt_val   = MID_W;
        w_all_mid   = 1'b0;
        w_sel_we    = 1'b0;
        w_slew_we   = 1'b0;
        if (rx_valid) begin
            if (w_is_cmd) begin
                w_state_nxt = (rx_data == "C") ? NUM_C : (rx_data == "A") ? NUM_A :
                              (rx_data == "P") ? NUM_P : NUM_S;
                w_acc_nxt   = '0;
                w_cnt_nxt   = '0;
                w_ovf_nxt   = 1'b0;
            end else if (w_is_dig && w_in_num) begin
                w_acc_nxt = w_acc_dig;
                w_cnt_nxt = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
                w_ovf_nxt = r_ovf | (r_cnt >= 3'd5);
            end else if (w_is_term && w_in_num) begin
                w_state_nxt = IDLE;
                w_err       = (r_cnt == '0) || r_ovf || (r_state == NUM_C && r_acc >= 16'(NCH));
                w_rpl_vld   = 1'b1;
                w_rpl       = w_err ? RPL_E : RPL_K;
                w_sel_we    = !w_err && (r_state == NUM_C);
                w_slew_we   = !w_err && (r_state == NUM_S);
                w_tgt_we    = !w_err && (r_state == NUM_A || r_state == NUM_P);
                w_tgt_val   = (r_state == NUM_A) ? angle_to_us(r_acc, MIN_W, MAX_W) :
                              (r_acc < MIN_W) ? MIN_W : (r_acc > MAX_W) ? MAX_W : r_acc;
            end else if (rx_data == "L" || rx_data == "R" || rx_data == "X") begin
                w_state_nxt = IDLE;
                w_rpl_vld   = 1'b1;
                w_rpl       = RPL_O;
                w_tgt_we    = 1'b1;
                w_tgt_val   = (rx_data == "L") ? MIN_W : (rx_data == "R") ? MAX_W : X_W;
            end else if (rx_data == "Z") begin
                w_state_nxt = IDLE;
                w_rpl_vld   = 1'b1;
                w_rpl       = RPL_O;
                w_all_mid   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Step is clamped to the remaining distance so the approach never overshoots or wraps.
    for (genvar c = 0; c < NCH; c++) begin : g_slew
        logic        w_up;
        logic [15:0] w_dist, w_step;
        assign w_up         = r_tgt[c] > r_cur[c];
        assign w_dist       = w_up ? r_tgt[c] - r_cur[c] : r_cur[c] - r_tgt[c];
        assign w_step       = (r_slew[c] < w_dist) ? r_slew[c] : w_dist;
        assign w_cur_nxt[c] = (r_slew[c] == '0) ? r_tgt[c] : !w_tick ? r_cur[c] :
                              w_up ? r_cur[c] + w_step : r_cur[c] - w_step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel       <= '0;
            r_step      <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_tgt[i]  <= MID_W;
                r_cur[i]  <= MID_W;
                r_slew[i] <= '0;
            end
        end else begin
            if (w_sel_we) r_sel <= r_acc[3:0];
            r_step <= w_tick ? '0 : r_step + SW'(1);
            for (int i = 0; i < NCH; i++) begin
                if (w_all_mid) r_tgt[i] <= MID_W;
                else if (w_tgt_we && r_sel == 4'(i)) r_tgt[i] <= w_tgt_val;
                if (w_slew_we && r_sel == 4'(i)) r_slew[i] <= r_acc;
                r_cur[i] <= w_cur_nxt[i];
            end
            // Single-entry reply slot: a newer reply replaces one still waiting on the UART.
            if (w_rpl_vld) begin
                r_pend      <= 1'b1;
                r_pend_data <= w_rpl;
            end else if (w_launch) begin
                r_pend <= 1'b0;
            end
            tx_start <= w_launch;
            if (w_launch) tx_data <= r_pend_data;
        end
    end

    servo_pwm_bank #(
        .NCH      (NCH),
        .US_DIV   (US_DIV),
        .FRAME_US (FRAME_US)
    ) u_pwm (
        .clk   (clk),
        .rst_n (rst_n),
        .i_cur (r_cur),
        .o_pwm (servo_pwm)
    );

endmodule

// File: tb/tb_bt_multi_servo_ctrl.sv
// tb_bt_multi_servo_ctrl: randomized command stimulus against a pulse-width and reply model,
// run at 1 MHz so one clock equals one microsecond of pulse width.
module tb_bt_multi_servo_ctrl;

    localparam int NCH = 4;
    localparam int FR  = 2560;
    localparam int MID = 1500;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           rx_valid = 1'b0;
    logic [7:0]     rx_data = 8'h00;
    logic           tx_busy = 1'b0;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [NCH-1:0] servo_pwm;

    int    n_cmp = 0;
    int    n_err = 0;
    int    exp_w [NCH];
    int    meas [NCH];
    string rs = "";

    always #5 clk = ~clk;

    bt_multi_servo_ctrl #(
        .CLK_FREQ (1_000_000),
        .NCH      (NCH),
        .MIN_US   (500),
        .MAX_US   (2500),
        .FRAME_US (FR),
        .STEP_MS  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .servo_pwm (servo_pwm)
    );

    always @(negedge clk) if (tx_start === 1'b1) rs = $sformatf("%s%c", rs, tx_data);

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired: got timeout, want completion");
        $fatal(1);
    end

    task automatic send_byte(input byte b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        repeat (4) @(negedge clk);
    endtask

    // Widths of the next complete frame; a missing frame leaves zeros, which no check accepts.
    task automatic measure_all();
        int t;
        for (int i = 0; i < NCH; i++) meas[i] = 0;
        t = 0;
        while (servo_pwm != '0 && t < FR + 100) begin @(negedge clk); t++; end
        t = 0;
        while (servo_pwm == '0 && t < FR + 100) begin @(negedge clk); t++; end
        t = 0;
        while (servo_pwm != '0 && t < FR + 100) begin
            for (int i = 0; i < NCH; i++) if (servo_pwm[i]) meas[i]++;
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < NCH; i++) exp_w[i] = MID;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b0 || tx_data !== 8'h00 || servo_pwm !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got start=%b data=%h pwm=%b want 0/00/0", tx_start, tx_data, servo_pwm);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (servo_pwm !== '1) begin
            n_err++;
            $display("FAIL reset_first_frame got pwm=%b want all high", servo_pwm);
        end
        measure_all();
        for (int i = 0; i < NCH; i++) begin
            n_cmp++;
            if (meas[i] != exp_w[i]) begin
                n_err++;
                $display("FAIL reset_width ch%0d got %0d want %0d", i, meas[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_pulse_p();
        rs = "";
        send_str("P1000\n");
        exp_w[0] = 1000;
        n_cmp++;
        if (rs != "K") begin n_err++; $display("FAIL p1000_reply got '%s' want 'K'", rs); end
        measure_all();
        for (int i = 0; i < NCH; i++) begin
            n_cmp++;
            if (meas[i] != exp_w[i]) begin
                n_err++;
                $display("FAIL p1000_width ch%0d got %0d want %0d", i, meas[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_angle();
        rs = "";
        send_str("C2\nA270\n");
        exp_w[2] = 500 + (29 * 270) / 4;
        n_cmp++;
        if (rs != "KK") begin n_err++; $display("FAIL a270_reply got '%s' want 'KK'", rs); end
        measure_all();
        n_cmp++;
        if (meas[2] != exp_w[2]) begin n_err++; $display("FAIL a270_width got %0d want %0d", meas[2], exp_w[2]); end
        send_str("A300\n");
        exp_w[2] = 2500;
        measure_all();
        n_cmp++;
        if (meas[2] != exp_w[2]) begin n_err++; $display("FAIL a300_width got %0d want %0d", meas[2], exp_w[2]); end
        rs = "";
        send_str("C9\nP1111\n");
        exp_w[2] = 1111;
        n_cmp++;
        if (rs != "EK") begin n_err++; $display("FAIL c9_reply got '%s' want 'EK'", rs); end
        measure_all();
        for (int i = 0; i < NCH; i++) begin
            n_cmp++;
            if (meas[i] != exp_w[i]) begin
                n_err++;
                $display("FAIL c9_sel_width ch%0d got %0d want %0d", i, meas[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_errors();
        rs = "";
        send_str("P123456\nP\n7\n");
        n_cmp++;
        if (rs != "EE") begin n_err++; $display("FAIL err_reply got '%s' want 'EE'", rs); end
        measure_all();
        n_cmp++;
        if (meas[2] != exp_w[2]) begin n_err++; $display("FAIL err_unchanged got %0d want %0d", meas[2], exp_w[2]); end
        send_str("P300\n");
        exp_w[2] = 500;
        n_cmp++;
        if (rs != "EEK") begin n_err++; $display("FAIL p300_reply got '%s' want 'EEK'", rs); end
        measure_all();
        n_cmp++;
        if (meas[2] != exp_w[2]) begin n_err++; $display("FAIL p300_clamp got %0d want %0d", meas[2], exp_w[2]); end
    endtask

    task automatic test_random();
        string jk = "#?!q~";
        for (int it = 0; it < 3; it++) begin
            int    ch, v;
            bit    is_a;
            string d, cmd;
            ch   = $urandom_range(0, NCH - 1);
            is_a = 1'($urandom_range(0, 1));
            v    = is_a ? $urandom_range(0, 400) : $urandom_range(0, 3000);
            d    = $sformatf("%0d", v);
            cmd  = is_a ? "A" : "P";
            for (int i = 0; i < d.len(); i++) begin
                if ($urandom_range(0, 2) == 0) cmd = $sformatf("%s%c", cmd, jk[$urandom_range(0, 4)]);
                cmd = $sformatf("%s%c", cmd, d[i]);
            end
            if (is_a) exp_w[ch] = (v > 270) ? 2500 : 500 + (29 * v) / 4;
            else exp_w[ch] = (v < 500) ? 500 : (v > 2500) ? 2500 : v;
            rs = "";
            send_str($sformatf("C%0d\r%s\n", ch, cmd));
            n_cmp++;
            if (rs != "KK") begin n_err++; $display("FAIL rand_reply it%0d got '%s' want 'KK'", it, rs); end
            measure_all();
            for (int i = 0; i < NCH; i++) begin
                n_cmp++;
                if (meas[i] != exp_w[i]) begin
                    n_err++;
                    $display("FAIL rand_width it%0d cmd=%s ch%0d got %0d want %0d", it, cmd, i, meas[i], exp_w[i]);
                end
            end
        end
        rs = "";
        send_str("X");
        n_cmp++;
        if (rs != "O") begin n_err++; $display("FAIL x_reply got '%s' want 'O'", rs); end
        send_str("Z");
        for (int i = 0; i < NCH; i++) exp_w[i] = MID;
        measure_all();
        for (int i = 0; i < NCH; i++) begin
            n_cmp++;
            if (meas[i] != exp_w[i]) begin
                n_err++;
                $display("FAIL z_width ch%0d got %0d want %0d", i, meas[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_reply_timing();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = "L";
        @(negedge clk);
        rx_valid = 1'b0;
        n_cmp++;
        if (tx_start !== 1'b0) begin n_err++; $display("FAIL reply_early got start=%b want 0", tx_start); end
        @(negedge clk);
        n_cmp++;
        if (tx_start !== 1'b1 || tx_data !== "O") begin
            n_err++;
            $display("FAIL reply_latency got start=%b data=%h want 1/4f", tx_start, tx_data);
        end
        send_str("Z");
    endtask

    task automatic test_back_to_back();
        tx_busy = 1'b1;
        repeat (4) @(negedge clk);
        rs = "";
        send_str("P\n");
        send_str("L");
        repeat (20) @(negedge clk);
        n_cmp++;
        if (rs != "") begin n_err++; $display("FAIL busy_hold got '%s' want ''", rs); end
        tx_busy = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (rs != "O") begin n_err++; $display("FAIL busy_latest got '%s' want 'O'", rs); end
        send_str("Z");
    endtask

    task automatic test_slew();
        int prev, w;
        bit mid_seen;
        rs = "";
        send_str("C0\nS200\nP2500\n");
        n_cmp++;
        if (rs != "KKK") begin n_err++; $display("FAIL slew_reply got '%s' want 'KKK'", rs); end
        prev     = MID;
        mid_seen = 1'b0;
        for (int f = 0; f < 8 && prev != 2500; f++) begin
            measure_all();
            w = meas[0];
            n_cmp++;
            if (w < prev || w > 2500 || (w - MID) % 200 != 0) begin
                n_err++;
                $display("FAIL slew_up_step frame%0d got %0d want multiple of 200 above %0d", f, w, prev);
            end
            if (w > MID && w < 2500) mid_seen = 1'b1;
            prev = w;
        end
        n_cmp++;
        if (prev != 2500 || !mid_seen) begin
            n_err++;
            $display("FAIL slew_up_end got %0d ramp=%0d want 2500 ramp=1", prev, mid_seen);
        end
        send_str("S400\nP1000\n");
        prev = 2500;
        for (int f = 0; f < 8 && prev != 1000; f++) begin
            measure_all();
            w = meas[0];
            n_cmp++;
            if (w > prev || w < 1000 || (w != 1000 && (2500 - w) % 400 != 0)) begin
                n_err++;
                $display("FAIL slew_down_step frame%0d got %0d want 400-step or 1000 below %0d", f, w, prev);
            end
            prev = w;
        end
        n_cmp++;
        if (prev != 1000 || meas[1] != MID) begin
            n_err++;
            $display("FAIL slew_down_end got ch0=%0d ch1=%0d want 1000/%0d", prev, meas[1], MID);
        end
        send_str("S0\n");
    endtask

    task automatic test_reset_mid();
        int t;
        send_str("C3\n");
        t = 0;
        while (servo_pwm == '0 && t < FR + 100) begin @(negedge clk); t++; end
        repeat (100) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (servo_pwm !== '0 || tx_start !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_async got pwm=%b start=%b want 0/0", servo_pwm, tx_start);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) exp_w[i] = MID;
        @(negedge clk);
        n_cmp++;
        if (servo_pwm !== '1) begin n_err++; $display("FAIL reset_mid_frame got pwm=%b want all high", servo_pwm); end
        measure_all();
        for (int i = 0; i < NCH; i++) begin
            n_cmp++;
            if (meas[i] != exp_w[i]) begin
                n_err++;
                $display("FAIL reset_mid_width ch%0d got %0d want %0d", i, meas[i], exp_w[i]);
            end
        end
        rs = "";
        send_str("P700\n");
        exp_w[0] = 700;
        measure_all();
        n_cmp++;
        if (rs != "K" || meas[0] != 700 || meas[3] != MID) begin
            n_err++;
            $display("FAIL reset_mid_sel got reply='%s' ch0=%0d ch3=%0d want 'K'/700/%0d", rs, meas[0], meas[3], MID);
        end
    endtask

    initial begin
        test_reset();
        test_pulse_p();
        test_angle();
        test_errors();
        test_random();
        test_reply_timing();
        test_back_to_back();
        test_slew();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
